counting_register_bank: RTL and testbench



---
 rtl/counting_register_bank.sv | 94 +++++++++
 tb/tb_counting_register_bank.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/counting_register_bank.sv
// Bank of NREGS counting registers with one shared load/inc/dec write path
// and two combinational read ports, with optional write forwarding.
module counting_register_bank #(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      NREGS       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      BYPASS      = 0,
  localparam int unsigned     SELW        = (NREGS > 2) ? $clog2(NREGS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] bus,
  input  logic [SELW-1:0]  sel,
  input  logic [1:0]       op,
  input  logic             en_bar,
  input  logic [SELW-1:0]  rsel_a,
  input  logic [SELW-1:0]  rsel_b,
  output logic [WIDTH-1:0] value_a,
  output logic [WIDTH-1:0] value_b,
  output logic             wrap,
  output logic             zero
);

  localparam logic [1:0] OpHold = 2'b00;
  localparam logic [1:0] OpLoad = 2'b01;
  localparam logic [1:0] OpInc  = 2'b10;
  localparam logic [1:0] OpDec  = 2'b11;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] nxt;
  logic             active;
  logic             wrap_d;
  logic             wrap_q;
  logic             zero_q;

  // Out-of-range selects (possible when NREGS is not a power of two) read as 0.
  function automatic logic [WIDTH-1:0] read_reg(input logic [SELW-1:0] idx);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < int'(NREGS); i++) begin
      if (idx == SELW'(i)) v = regs_q[i];
    end
    return v;
  endfunction

  always_comb begin
    active = !en_bar && (op != OpHold) && (32'(sel) < NREGS);
    cur    = read_reg(sel);
    nxt    = cur;
    wrap_d = 1'b0;
    if (active) begin
      case (op)
        OpLoad: nxt = bus;
        OpInc: begin
          nxt    = cur + WIDTH'(1);
          wrap_d = &cur;
        end
        OpDec: begin
          nxt    = cur - WIDTH'(1);
          wrap_d = ~|cur;
        end
        default: nxt = cur;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= RESET_VALUE;
      wrap_q <= 1'b0;
      zero_q <= (RESET_VALUE == '0);
    end else begin
      wrap_q <= wrap_d;
      for (int i = 0; i < int'(NREGS); i++) begin
        if (active && (sel == SELW'(i))) regs_q[i] <= nxt;
      end
      if (active) zero_q <= (nxt == '0);
    end
  end

  always_comb begin
    value_a = read_reg(rsel_a);
    value_b = read_reg(rsel_b);
    if (BYPASS != 0 && active) begin
      if (rsel_a == sel) value_a = nxt;
      if (rsel_b == sel) value_b = nxt;
    end
  end

  assign wrap = wrap_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_counting_register_bank.sv
// Scoreboard bench: a default bank and a 3-register forwarding bank with a
// non-zero reset value, driven with identical stimulus.
module tb_counting_register_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bus;
  logic [1:0]  sel, op, rsel_a, rsel_b;
  logic        en_bar;
  logic [15:0] va0, vb0, va1, vb1;
  logic        w0, z0, w1, z1;

  always #5 clk = ~clk;

  counting_register_bank u_dut0 (
    .clk(clk), .reset(reset), .bus(bus), .sel(sel), .op(op), .en_bar(en_bar),
    .rsel_a(rsel_a), .rsel_b(rsel_b), .value_a(va0), .value_b(vb0), .wrap(w0), .zero(z0)
  );

  counting_register_bank #(
    .WIDTH(16), .NREGS(3), .RESET_VALUE(16'h00FF), .BYPASS(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus), .sel(sel), .op(op), .en_bar(en_bar),
    .rsel_a(rsel_a), .rsel_b(rsel_b), .value_a(va1), .value_b(vb1), .wrap(w1), .zero(z1)
  );

  typedef struct {
    logic [15:0] a0, b0, a1, b1;
    logic        w0, z0, w1, z1;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m0 [4];
  logic [15:0] m1 [4];
  logic        mw0, mz0, mw1, mz1;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {wrap, new value}.
  function automatic logic [16:0] step(input logic [15:0] old, input logic [1:0] o,
                                       input logic [15:0] b);
    case (o)
      2'd1:    return {1'b0, b};
      2'd2:    return {old == 16'hFFFF, old + 16'd1};
      2'd3:    return {old == 16'h0000, old - 16'd1};
      default: return {1'b0, old};
    endcase
  endfunction

  function automatic logic [15:0] rd1(input logic [1:0] idx);
    return (idx < 2'd3) ? m1[idx] : 16'h0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m0[i] = 16'h0000;
      m1[i] = 16'h00FF;
    end
    mw0 = 1'b0; mz0 = 1'b1;
    mw1 = 1'b0; mz1 = 1'b0;
  endtask

  task automatic apply(input logic [1:0] s, input logic [1:0] o, input logic e,
                       input logic [15:0] b, input logic [1:0] ra, input logic [1:0] rb);
    logic [16:0] r;
    logic        act0, act1;
    exp_t        x, got;
    @(negedge clk);
    sel = s; op = o; en_bar = e; bus = b; rsel_a = ra; rsel_b = rb;
    act0 = !e && (o != 2'd0);
    act1 = act0 && (s < 2'd3);
    #1;
    chk("pre_a0", va0, m0[ra]);
    chk("pre_b0", vb0, m0[rb]);
    r = step(rd1(s), o, b);
    chk("pre_a1_fwd", va1, (act1 && ra == s) ? r[15:0] : rd1(ra));
    chk("pre_b1_fwd", vb1, (act1 && rb == s) ? r[15:0] : rd1(rb));
    if (act0) begin
      r = step(m0[s], o, b);
      m0[s] = r[15:0]; mw0 = r[16]; mz0 = (r[15:0] == 16'h0);
    end else mw0 = 1'b0;
    if (act1) begin
      r = step(m1[s], o, b);
      m1[s] = r[15:0]; mw1 = r[16]; mz1 = (r[15:0] == 16'h0);
    end else mw1 = 1'b0;
    x.a0 = m0[ra]; x.b0 = m0[rb]; x.a1 = rd1(ra); x.b1 = rd1(rb);
    x.w0 = mw0; x.z0 = mz0; x.w1 = mw1; x.z1 = mz1;
    sb.push_back(x);
    @(posedge clk);
    #1;
    en_bar = 1'b1; op = 2'd0;  // drop the op so forwarding cannot mask stored values
    #1;
    got = sb.pop_front();
    chk("post_a0", va0, got.a0);
    chk("post_b0", vb0, got.b0);
    chk("post_a1", va1, got.a1);
    chk("post_b1", vb1, got.b1);
    chk("wrap0", 16'(w0), 16'(got.w0));
    chk("zero0", 16'(z0), 16'(got.z0));
    chk("wrap1", 16'(w1), 16'(got.w1));
    chk("zero1", 16'(z1), 16'(got.z1));
  endtask

  initial begin
    logic [15:0] bv;
    reset = 1'b1; en_bar = 1'b1; op = 2'd0; sel = 2'd0; bus = 16'h0;
    rsel_a = 2'd0; rsel_b = 2'd1;
    #3;
    chk("rst_a0", va0, 16'h0000);
    chk("rst_a1", va1, 16'h00FF);
    chk("rst_z0", 16'(z0), 16'd1);
    chk("rst_z1", 16'(z1), 16'd0);
    chk("rst_w0", 16'(w0), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Mid-cycle asynchronous reset with a pending increment held across an edge.
    apply(2'd1, 2'd1, 1'b0, 16'h1234, 2'd1, 2'd0);
    @(negedge clk);
    rsel_a = 2'd1; rsel_b = 2'd2;
    #2 reset = 1'b1;
    #1;
    chk("async_a0", va0, 16'h0000);
    chk("async_a1", va1, 16'h00FF);
    chk("async_z0", 16'(z0), 16'd1);
    chk("async_w0", 16'(w0), 16'd0);
    sel = 2'd1; op = 2'd2; en_bar = 1'b0;
    @(posedge clk);
    #1;
    en_bar = 1'b1; op = 2'd0;
    #1;
    chk("rst_dom_a0", va0, 16'h0000);
    chk("rst_dom_a1", va1, 16'h00FF);
    chk("rst_dom_z1", 16'(z1), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Load and disabled load.
    apply(2'd2, 2'd1, 1'b0, 16'hBEEF, 2'd0, 2'd2);
    apply(2'd2, 2'd1, 1'b1, 16'h1111, 2'd1, 2'd2);
    // Increment wrap, then hold.
    apply(2'd0, 2'd1, 1'b0, 16'hFFFF, 2'd0, 2'd0);
    apply(2'd0, 2'd2, 1'b0, 16'h0000, 2'd0, 2'd1);
    apply(2'd0, 2'd0, 1'b0, 16'h0000, 2'd0, 2'd1);
    // Decrement wrap on reg3 (out of range for the 3-register bank).
    apply(2'd3, 2'd3, 1'b0, 16'h0000, 2'd3, 2'd3);
    apply(2'd3, 2'd1, 1'b0, 16'h0001, 2'd3, 2'd0);
    apply(2'd3, 2'd3, 1'b0, 16'h0000, 2'd3, 2'd2);
    // Forwarding: increment reg1 while both ports watch reg1 and reg0.
    apply(2'd1, 2'd1, 1'b0, 16'h0010, 2'd1, 2'd0);
    apply(2'd1, 2'd2, 1'b0, 16'h0000, 2'd1, 2'd0);
    apply(2'd1, 2'd3, 1'b0, 16'h0000, 2'd1, 2'd1);
    // Out-of-range load on the 3-register bank.
    apply(2'd3, 2'd1, 1'b0, 16'hAAAA, 2'd3, 2'd1);

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 4))
        0:       bv = 16'h0000;
        1:       bv = 16'h0001;
        2:       bv = 16'hFFFF;
        3:       bv = 16'hFFFE;
        default: bv = 16'($urandom);
      endcase
      apply(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0),
            bv, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
